// File: rtl/disp_page_sched_pkg.sv
// Shared constants and helpers for the display page scheduler.
package disp_page_sched_pkg;

  localparam int unsigned PG_W      = 2;
  localparam int unsigned NUM_PG    = 3;
  localparam int unsigned CLAMP_MAX = 99;

  localparam logic [PG_W-1:0] PG_STATUS = 2'd0;
  localparam logic [PG_W-1:0] PG_CONFIG = 2'd1;
  localparam logic [PG_W-1:0] PG_ALERT  = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHOW   = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  // Highest-priority requester: alert > config > status (status when none).
  function automatic logic [PG_W-1:0] pick_win(input logic [NUM_PG-1:0] req);
    if (req[PG_ALERT])       return PG_ALERT;
    else if (req[PG_CONFIG]) return PG_CONFIG;
    else                     return PG_STATUS;
  endfunction

  // Page index to one-hot grant vector.
  function automatic logic [NUM_PG-1:0] pg_onehot(input logic [PG_W-1:0] pg);
    return 3'b001 << pg;
  endfunction

endpackage

// File: rtl/disp_page_sched_clamp.sv
// Combinational clamp of a page value to the two-digit range 0..99.
module page_clamp
  import disp_page_sched_pkg::*;
#(
  parameter int unsigned VAL_W = 7
) (
  input  logic [VAL_W-1:0] val,
  output logic [VAL_W-1:0] val_c
);

  // Saturate anything above the two-digit limit.
  always_comb begin
    val_c = val;
    if (32'(val) > CLAMP_MAX) val_c = VAL_W'(CLAMP_MAX);
  end

endmodule

// File: rtl/disp_page_sched.sv
// Shares one 4-digit display between status, config and alert pages with
// fixed priority, minimum dwell, a blank gap on page changes and alert blink.
module disp_page_sched
  import disp_page_sched_pkg::*;
#(
  parameter int unsigned VAL_W       = 7,
  parameter int unsigned DWELL_TICKS = 1000,
  parameter int unsigned BLINK_HALF  = 250,
  parameter int unsigned CNT_W       = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              tick,
  input  logic [2:0]        req,
  input  logic [VAL_W-1:0]  st_hi,
  input  logic [VAL_W-1:0]  st_lo,
  input  logic [VAL_W-1:0]  cf_hi,
  input  logic [VAL_W-1:0]  cf_lo,
  input  logic [VAL_W-1:0]  al_hi,
  input  logic [VAL_W-1:0]  al_lo,
  output logic [2:0]        grant,
  output logic [VAL_W-1:0]  out_hi,
  output logic [VAL_W-1:0]  out_lo,
  output logic              blank
);

  logic [1:0]       state_q, state_d;
  logic [PG_W-1:0]  pg_q, pg_d;
  logic [2:0]       grant_q, grant_d;
  logic [VAL_W-1:0] out_hi_q, out_hi_d;
  logic [VAL_W-1:0] out_lo_q, out_lo_d;
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  logic [PG_W-1:0]  win_pg;
  logic             any_req;
  logic             leave_show;
  logic [PG_W-1:0]  sel_pg;
  logic [VAL_W-1:0] raw_hi, raw_lo;
  logic [VAL_W-1:0] hi_c, lo_c;

  // Arbitration: winner and the reasons to leave the shown page.
  always_comb begin
    win_pg     = pick_win(req);
    any_req    = |req;
    leave_show = (req[PG_ALERT] && (pg_q != PG_ALERT))
               || !req[pg_q]
               || ((dwell_q == '0) && any_req && (win_pg != pg_q));
    sel_pg     = (state_q == ST_SHOW) ? pg_q : win_pg;
  end

  // Source mux for the page about to be registered.
  always_comb begin
    raw_hi = '0;
    raw_lo = '0;
    case (sel_pg)
      PG_STATUS: begin raw_hi = st_hi; raw_lo = st_lo; end
      PG_CONFIG: begin raw_hi = cf_hi; raw_lo = cf_lo; end
      PG_ALERT:  begin raw_hi = al_hi; raw_lo = al_lo; end
      default:   begin raw_hi = '0;    raw_lo = '0;    end
    endcase
  end

  page_clamp #(.VAL_W(VAL_W)) u_clamp_hi (.val(raw_hi), .val_c(hi_c));
  page_clamp #(.VAL_W(VAL_W)) u_clamp_lo (.val(raw_lo), .val_c(lo_c));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pg_d        = pg_q;
    grant_d     = grant_q;
    out_hi_d    = out_hi_q;
    out_lo_d    = out_lo_q;
    blank_d     = blank_q;
    dwell_d     = dwell_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (any_req) begin
          state_d     = ST_SHOW;
          pg_d        = win_pg;
          grant_d     = pg_onehot(win_pg);
          out_hi_d    = hi_c;
          out_lo_d    = lo_c;
          blank_d     = 1'b0;
          dwell_d     = CNT_W'(DWELL_TICKS);
          blink_cnt_d = CNT_W'(BLINK_HALF);
          blink_ph_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          blank_d = 1'b1;
        end
      end
      ST_SHOW: begin
        if (leave_show) begin
          state_d = ST_SWITCH;
          grant_d = '0;
          blank_d = 1'b1;
        end else begin
          out_hi_d = hi_c;
          out_lo_d = lo_c;
          if (tick && (dwell_q != '0)) dwell_d = dwell_q - CNT_W'(1);
          if (pg_q == PG_ALERT) begin
            if (tick) begin
              if (blink_cnt_q <= CNT_W'(1)) begin
                blink_cnt_d = CNT_W'(BLINK_HALF);
                blink_ph_d  = ~blink_ph_q;
              end else begin
                blink_cnt_d = blink_cnt_q - CNT_W'(1);
              end
            end
            blank_d = blink_ph_d;
          end else begin
            blank_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        blank_d = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      pg_q        <= PG_STATUS;
      grant_q     <= '0;
      out_hi_q    <= '0;
      out_lo_q    <= '0;
      blank_q     <= 1'b1;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pg_q        <= pg_d;
      grant_q     <= grant_d;
      out_hi_q    <= out_hi_d;
      out_lo_q    <= out_lo_d;
      blank_q     <= blank_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign grant  = grant_q;
  assign out_hi = out_hi_q;
  assign out_lo = out_lo_q;
  assign blank  = blank_q;

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed self-checking bench for disp_page_sched (DWELL_TICKS=4, BLINK_HALF=2).
module tb_disp_page_sched;

  localparam int unsigned VAL_W = 7;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             tick = 1'b1;
  logic [2:0]       req = 3'b000;
  logic [VAL_W-1:0] st_hi = 7'd12, st_lo = 7'd34;
  logic [VAL_W-1:0] cf_hi = 7'd56, cf_lo = 7'd78;
  logic [VAL_W-1:0] al_hi = 7'd90, al_lo = 7'd11;
  logic [2:0]       grant;
  logic [VAL_W-1:0] out_hi, out_lo;
  logic             blank;

  int n_checks = 0;
  int n_errors = 0;

  disp_page_sched #(
    .VAL_W(VAL_W), .DWELL_TICKS(4), .BLINK_HALF(2), .CNT_W(10)
  ) dut (
    .Clk(Clk), .Rst(Rst), .tick(tick), .req(req),
    .st_hi(st_hi), .st_lo(st_lo), .cf_hi(cf_hi), .cf_lo(cf_lo),
    .al_hi(al_hi), .al_lo(al_lo),
    .grant(grant), .out_hi(out_hi), .out_lo(out_lo), .blank(blank)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Blank pattern expected from alert entry onward.
  logic [5:0] blink_exp;

  initial begin
    blink_exp = 6'b001100;

    // Reset state.
    #2 Rst = 1'b1;
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_hi",    32'(out_hi), 32'd0);
    chk("rst_lo",    32'(out_lo), 32'd0);
    step();
    @(negedge Clk);
    Rst = 1'b0;
    req = 3'b001;

    // Test 1: first grant straight from IDLE.
    step();
    chk("t1_grant", 32'(grant), 32'b001);
    chk("t1_hi",    32'(out_hi), 32'd12);
    chk("t1_lo",    32'(out_lo), 32'd34);
    chk("t1_blank", 32'(blank), 32'd0);

    // Asynchronous reset mid-SHOW.
    #2 Rst = 1'b1;
    #1;
    chk("t1_arst_grant", 32'(grant), 32'd0);
    chk("t1_arst_blank", 32'(blank), 32'd1);
    @(negedge Clk);
    Rst = 1'b0;
    step();
    chk("t1_regrant", 32'(grant), 32'b001);
    chk("t1_reblank", 32'(blank), 32'd0);

    // Test 2: config waits for status dwell, then one blank gap.
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_hold", 32'(grant), 32'b001);
    end
    step();
    chk("t2_gap_grant", 32'(grant), 32'd0);
    chk("t2_gap_blank", 32'(blank), 32'd1);
    step();
    chk("t2_cf_grant", 32'(grant), 32'b010);
    chk("t2_cf_hi",    32'(out_hi), 32'd56);
    chk("t2_cf_lo",    32'(out_lo), 32'd78);
    chk("t2_cf_blank", 32'(blank), 32'd0);

    // Test 3: alert preempts config regardless of dwell, then blinks.
    req = 3'b111;
    step();
    chk("t3_gap_grant", 32'(grant), 32'd0);
    chk("t3_gap_blank", 32'(blank), 32'd1);
    step();
    chk("t3_al_grant", 32'(grant), 32'b100);
    chk("t3_al_hi",    32'(out_hi), 32'd90);
    chk("t3_al_lo",    32'(out_lo), 32'd11);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) step();
      chk("t3_blink", 32'(blank), 32'(blink_exp[i]));
      chk("t3_blink_grant", 32'(grant), 32'b100);
    end

    // Test 5a: alert drops to nothing -> SWITCH then IDLE.
    req = 3'b000;
    step();
    chk("t5_sw_grant", 32'(grant), 32'd0);
    chk("t5_sw_blank", 32'(blank), 32'd1);
    chk("t5_sw_hold",  32'(out_hi), 32'd90);
    step();
    chk("t5_idle_grant", 32'(grant), 32'd0);
    chk("t5_idle_blank", 32'(blank), 32'd1);
    step();
    chk("t5_idle2_grant", 32'(grant), 32'd0);

    // Test 4: clamp on the status page.
    st_hi = 7'd127;
    st_lo = 7'd100;
    req = 3'b001;
    step();
    chk("t4_grant", 32'(grant), 32'b001);
    chk("t4_hi127", 32'(out_hi), 32'd99);
    chk("t4_lo100", 32'(out_lo), 32'd99);
    st_lo = 7'd99;
    step();
    chk("t4_lo99", 32'(out_lo), 32'd99);
    st_lo = 7'd0;
    step();
    chk("t4_lo0", 32'(out_lo), 32'd0);
    chk("t4_hi_still", 32'(out_hi), 32'd99);
    st_hi = 7'd12;
    st_lo = 7'd34;
    step();
    chk("t4_live_hi", 32'(out_hi), 32'd12);
    chk("t4_live_lo", 32'(out_lo), 32'd34);

    // Test 5b: no ticks, dwell frozen, config stays pending behind status.
    tick = 1'b0;
    req = 3'b011;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_notick_hold", 32'(grant), 32'b001);
    end
    tick = 1'b1;

    // Test 6: alert rises while status drops in the same cycle.
    req = 3'b110;
    step();
    chk("t6_gap_grant", 32'(grant), 32'd0);
    chk("t6_gap_blank", 32'(blank), 32'd1);
    step();
    chk("t6_al_grant", 32'(grant), 32'b100);
    chk("t6_al_blank", 32'(blank), 32'd0);

    // Random requests: grant must never be multi-hot.
    for (int i = 0; i < 10000; i++) begin
      @(negedge Clk);
      req  = 3'($urandom_range(0, 7));
      tick = 1'($urandom_range(0, 1));
      step();
      chk("onehot0", 32'($onehot0(grant)), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
